// File: rtl/inst_fetch_buffer_pkg.sv
// Shared fetch-buffer definitions: FSM encodings, fetch width, data width and entry layout.
package inst_fetch_buffer_pkg;

  localparam int data_lentgh = 32;
  localparam int FETCH_WIDTH = 4;
  localparam int ENTRY_W     = 2 * data_lentgh;

  typedef enum logic [1:0] {
    FB_IDLE = 2'd0,
    FB_REQ  = 2'd1,
    FB_WAIT = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic [data_lentgh-1:0] pc;
    logic [data_lentgh-1:0] inst;
  } fb_entry_t;

endpackage

// File: rtl/inst_fetch_buffer_ram.sv
// Circular {pc, inst} storage: writes FETCH_WIDTH consecutive entries (wrapping) per cycle,
// one asynchronous read port; contents clear on reset so the head reads 0 out of reset.
module inst_fetch_buffer_ram
  import inst_fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic [AW-1:0]                  waddr_i,
  input  logic [FETCH_WIDTH*ENTRY_W-1:0] wdata_i,
  input  logic [AW-1:0]                  raddr_i,
  output logic [ENTRY_W-1:0]             rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < FETCH_WIDTH; i++)
        mem_q[waddr_i + AW'(i)] <= wdata_i[i*ENTRY_W +: ENTRY_W];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_buffer.sv
// 4-wide instruction fetch into a circular buffer, one instruction per cycle to decode; redirect flushes.
// Optional FETCH_BUFFER_PERF_EN adds saturating starve/full counters (ports tied to 0 otherwise).
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] inst_address,
  output logic        InstMem_Read,
  input  logic        InstMem_Ready,
  input  logic [31:0] inst1_in,
  input  logic [31:0] inst2_in,
  input  logic [31:0] inst3_in,
  input  logic [31:0] inst4_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  output logic [31:0] perf_starve,
  output logic [31:0] perf_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fb_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic read, push, pop, space_ok;
  logic [31:0] fetch_inst [FETCH_WIDTH];
  logic [FETCH_WIDTH*ENTRY_W-1:0] wdata;
  fb_entry_t head;

  // Request decision uses the registered count, so space freed by a pop is seen next cycle.
  assign space_ok = (count_q <= CW'(DEPTH - FETCH_WIDTH));

  always_comb begin
    state_d = state_q;
    read    = 1'b0;
    unique case (state_q)
      FB_IDLE: state_d = FB_REQ;
      FB_REQ: begin
        read = space_ok && !redirect_valid;
        if (read && !InstMem_Ready) state_d = FB_WAIT;
      end
      FB_WAIT: begin
        read = 1'b1;
        if (InstMem_Ready) state_d = FB_REQ;
      end
      default: state_d = FB_IDLE;
    endcase
    if (redirect_valid) state_d = FB_REQ;
  end

  assign push = read && InstMem_Ready && !redirect_valid;
  assign pop  = dec_valid && dec_ready && !redirect_valid;

  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(FETCH_WIDTH);
        fetch_pc_d = fetch_pc_q + 32'(FETCH_WIDTH * 4);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (push ? CW'(FETCH_WIDTH) : CW'(0)) - (pop ? CW'(1) : CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FB_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  assign fetch_inst[0] = inst1_in;
  assign fetch_inst[1] = inst2_in;
  assign fetch_inst[2] = inst3_in;
  assign fetch_inst[3] = inst4_in;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      wdata[i*ENTRY_W +: ENTRY_W] = {fetch_pc_q + 32'(4 * i), fetch_inst[i]};
  end

  inst_fetch_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign inst_address = fetch_pc_q;
  assign InstMem_Read = read;
  assign dec_valid    = (count_q != '0);
  assign dec_inst     = head.inst;
  assign dec_pc       = head.pc;

`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0] starve_q, full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      full_q   <= '0;
    end else begin
      if (dec_ready && !dec_valid && starve_q != '1) starve_q <= starve_q + 32'd1;
      if (state_q == FB_REQ && !space_ok && full_q != '1) full_q <= full_q + 32'd1;
    end
  end

  assign perf_starve = starve_q;
  assign perf_full   = full_q;
`else
  assign perf_starve = '0;
  assign perf_full   = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Scoreboard bench for inst_fetch_buffer with a configurable-latency instruction memory model.
module tb_inst_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_address;
  logic        InstMem_Read, InstMem_Ready;
  logic [31:0] inst1_in, inst2_in, inst3_in, inst4_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_inst, dec_pc, perf_starve, perf_full;

  int checks = 0;
  int errors = 0;
  int mem_delay, wait_cnt;
  logic mem_en, force_rdy;
  int push_cnt, pop_cnt;
  logic [31:0] last_push_addr, last_pop_pc;
  logic [63:0] sbq [$];

  always #5 clk = ~clk;

  inst_fetch_buffer #(.DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .inst_address(inst_address), .InstMem_Read(InstMem_Read), .InstMem_Ready(InstMem_Ready),
    .inst1_in(inst1_in), .inst2_in(inst2_in), .inst3_in(inst3_in), .inst4_in(inst4_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc), .dec_ready(dec_ready),
    .perf_starve(perf_starve), .perf_full(perf_full)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0001_0101;
  endfunction

  assign inst1_in = mem_word(inst_address);
  assign inst2_in = mem_word(inst_address + 32'd4);
  assign inst3_in = mem_word(inst_address + 32'd8);
  assign inst4_in = mem_word(inst_address + 32'd12);
  assign InstMem_Ready = (InstMem_Read && mem_en && (wait_cnt >= mem_delay)) || force_rdy;

  always @(posedge clk) begin
    if (rst || !InstMem_Read || InstMem_Ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: entries queued on each accepted fetch, compared as decode consumes them.
  always @(negedge clk) begin
    logic [63:0] e;
    logic do_push, do_pop;
    if (rst) begin
      sbq.delete();
    end else begin
      chk("count", 64'(dut.count_q), 64'(sbq.size()));
      chk("dec_valid", 64'(dec_valid), 64'(sbq.size() != 0));
      do_push = InstMem_Read && InstMem_Ready && !redirect_valid;
      do_pop  = dec_valid && dec_ready && !redirect_valid;
      if (do_push) chk("push_space", 64'(sbq.size() <= 4), 64'd1);
      if (do_pop && sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("dec_pc", 64'(dec_pc), 64'(e[63:32]));
        chk("dec_inst", 64'(dec_inst), 64'(e[31:0]));
        pop_cnt++;
        last_pop_pc = dec_pc;
      end
      if (redirect_valid) sbq.delete();
      else if (do_push) begin
        for (int i = 0; i < 4; i++)
          sbq.push_back({inst_address + 32'(4 * i), mem_word(inst_address + 32'(4 * i))});
        push_cnt++;
        last_push_addr = inst_address;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    push_cnt = 0;
    pop_cnt  = 0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_delay = 0; mem_en = 1'b1; force_rdy = 1'b0;
    push_cnt = 0; pop_cnt = 0; last_push_addr = '0; last_pop_pc = '0;

    // Zero-latency memory, always-ready decode: continuous stream.
    tick(1);
    chk("rst_read", 64'(InstMem_Read), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_pc", 64'(dec_pc), 64'd0);
    chk("rst_dec_inst", 64'(dec_inst), 64'd0);
    dec_ready = 1'b1;
    do_reset();
    @(negedge clk);
    chk("t1_idle_read", 64'(InstMem_Read), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_first_read", 64'(InstMem_Read), 64'd1);
    chk("t1_first_addr", 64'(inst_address), 64'd0);
    @(posedge clk); #1;
    begin
      int gaps = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (!dec_valid) gaps++;
        @(posedge clk); #1;
      end
      chk("t1_gaps", 64'(gaps), 64'd0);
      chk("t1_pops", 64'(pop_cnt), 64'd40);
    end

    // Decode stalled: buffer fills with two blocks, then drains four.
    dec_ready = 1'b0;
    do_reset();
    tick(6);
    @(negedge clk);
    chk("t2_full_read", 64'(InstMem_Read), 64'd0);
    chk("t2_pushes", 64'(push_cnt), 64'd2);
    chk("t2_last_addr", 64'(last_push_addr), 64'd16);
`ifndef FETCH_BUFFER_PERF_EN
    chk("perf_starve_tied", 64'(perf_starve), 64'd0);
    chk("perf_full_tied", 64'(perf_full), 64'd0);
`endif
    @(posedge clk); #1;
    dec_ready = 1'b1;
    tick(4);
    dec_ready = 1'b0;
    chk("t2_pops", 64'(pop_cnt), 64'd4);
    chk("t2_last_pop", 64'(last_pop_pc), 64'd12);
    @(negedge clk);
    chk("t2_resume_read", 64'(InstMem_Read), 64'd1);
    chk("t2_resume_addr", 64'(inst_address), 64'd32);
    @(posedge clk); #1;

    // Memory answers after 3 wait cycles; request must hold stable.
    mem_delay = 3;
    do_reset();
    for (int c = 0; c < 20 && push_cnt < 1; c++) tick(1);
    chk("t3_first_push", 64'(push_cnt), 64'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_wait_read", 64'(InstMem_Read), 64'd1);
      chk("t3_wait_addr", 64'(inst_address), 64'd16);
      chk("t3_wait_nopush", 64'(push_cnt), 64'd1);
      @(posedge clk); #1;
    end
    tick(1);
    chk("t3_push_done", 64'(push_cnt), 64'd2);
    chk("t3_push_addr", 64'(last_push_addr), 64'd16);
    dec_ready = 1'b1;
    tick(4);
    dec_ready = 1'b0;
    tick(1);
    // Reset while the request to 32 is pending, with Ready arriving on the reset edge.
    rst = 1'b1; force_rdy = 1'b1;
    tick(1);
    rst = 1'b0; force_rdy = 1'b0;
    @(negedge clk);
    chk("t3_rst_nopush", 64'(push_cnt), 64'd2);
    chk("t3_rst_read", 64'(InstMem_Read), 64'd0);
    chk("t3_rst_valid", 64'(dec_valid), 64'd0);
    @(posedge clk); #1;

    // Redirect while a fetch is pending in WAIT; stale Ready and pop in that cycle are ignored.
    mem_delay = 0;
    do_reset();
    for (int c = 0; c < 20 && push_cnt < 1; c++) tick(1);
    mem_delay = 10;
    tick(2);
    redirect_valid = 1'b1; redirect_pc = 32'h100; force_rdy = 1'b1; dec_ready = 1'b1;
    mem_delay = 0;
    tick(1);
    redirect_valid = 1'b0; force_rdy = 1'b0; dec_ready = 1'b0;
    @(negedge clk);
    chk("t4_flush_valid", 64'(dec_valid), 64'd0);
    chk("t4_no_stale_push", 64'(push_cnt), 64'd1);
    chk("t4_redir_addr", 64'(inst_address), 64'h100);
    @(posedge clk); #1;
    dec_ready = 1'b1;
    @(negedge clk);
    chk("t4_first_pc", 64'(dec_pc), 64'h100);
    tick(12);
    dec_ready = 1'b0;

`ifdef FETCH_BUFFER_PERF_EN
    mem_en = 1'b0;
    do_reset();
    tick(2);
    dec_ready = 1'b1;
    tick(10);
    dec_ready = 1'b0;
    @(negedge clk);
    chk("perf_starve", 64'(perf_starve), 64'd10);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("perf_starve_rst", 64'(perf_starve), 64'd0);
    mem_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
